// File: rtl/kfpga_config_pkg.sv
// Shared configuration constants and loader state encoding.
// Lets the fabric top derive CHAIN_LENGTH from the tile config width.
package kfpga_config_pkg;

    localparam int CONFIG_WORD_WIDTH = 32;
    localparam int TILE_CONFIG_WIDTH = 146;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_WORD = 2'd1,
        ST_SHIFT     = 2'd2,
        ST_DONE      = 2'd3
    } load_state_t;

endpackage

// File: rtl/config_bitstream_loader.sv
// Serialises valid/ready bitstream words MSB-first onto the config chain.
// Ports: clock, reset (sync, active-high), start pulse, word_data/
// word_valid/word_ready stream in, config_data/config_enable to the
// chain, busy while loading, done once CHAIN_LENGTH bits are shifted.
module config_bitstream_loader
    import kfpga_config_pkg::*;
#(
    parameter int WORD_WIDTH   = CONFIG_WORD_WIDTH,
    parameter int CHAIN_LENGTH = 9 * TILE_CONFIG_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WORD_WIDTH-1:0] word_data,
    input  logic                  word_valid,
    output logic                  word_ready,
    output logic                  config_data,
    output logic                  config_enable,
    output logic                  busy,
    output logic                  done
);

    localparam int BIT_CNT_W  = $clog2(CHAIN_LENGTH + 1);
    localparam int WORD_CNT_W = $clog2(WORD_WIDTH + 1);

    localparam logic [BIT_CNT_W-1:0] LAST_CHAIN_BIT =
        BIT_CNT_W'(CHAIN_LENGTH - 1);
    localparam logic [WORD_CNT_W-1:0] LAST_WORD_BIT =
        WORD_CNT_W'(WORD_WIDTH - 1);

    load_state_t             state;
    load_state_t             state_next;
    logic [WORD_WIDTH-1:0]   word_reg;
    logic [WORD_WIDTH-1:0]   word_reg_next;
    logic [BIT_CNT_W-1:0]    bit_cnt;
    logic [BIT_CNT_W-1:0]    bit_cnt_next;
    logic [WORD_CNT_W-1:0]   word_bit_cnt;
    logic [WORD_CNT_W-1:0]   word_bit_cnt_next;

    logic last_chain_bit;
    logic last_word_bit;

    assign last_chain_bit = (bit_cnt == LAST_CHAIN_BIT);
    assign last_word_bit  = (word_bit_cnt == LAST_WORD_BIT);

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= ST_IDLE;
            word_reg     <= '0;
            bit_cnt      <= '0;
            word_bit_cnt <= '0;
        end else begin
            state        <= state_next;
            word_reg     <= word_reg_next;
            bit_cnt      <= bit_cnt_next;
            word_bit_cnt <= word_bit_cnt_next;
        end
    end

    always_comb begin
        state_next        = state;
        word_reg_next     = word_reg;
        bit_cnt_next      = bit_cnt;
        word_bit_cnt_next = word_bit_cnt;
        word_ready        = 1'b0;

        unique case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_next        = ST_WAIT_WORD;
                    bit_cnt_next      = '0;
                    word_bit_cnt_next = '0;
                end
            end

            ST_WAIT_WORD: begin
                word_ready = 1'b1;
                if (word_valid) begin
                    word_reg_next     = word_data;
                    word_bit_cnt_next = '0;
                    state_next        = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                bit_cnt_next = bit_cnt + 1'b1;
                // Chain completion wins over word boundary, so a
                // partial final word is dropped and no extra word
                // is requested.
                if (last_chain_bit) begin
                    state_next = ST_DONE;
                end else if (last_word_bit) begin
                    // Offer the next word on the last bit so that
                    // back-to-back words shift without a gap.
                    word_ready        = 1'b1;
                    word_bit_cnt_next = '0;
                    if (word_valid) begin
                        word_reg_next = word_data;
                    end else begin
                        state_next = ST_WAIT_WORD;
                    end
                end else begin
                    word_reg_next     = word_reg << 1;
                    word_bit_cnt_next = word_bit_cnt + 1'b1;
                end
            end

            default: state_next = ST_IDLE;
        endcase
    end

    // Outputs decode the state register only.
    assign config_enable = (state == ST_SHIFT);
    assign config_data   = config_enable & word_reg[WORD_WIDTH-1];
    assign busy          = (state == ST_WAIT_WORD) ||
                           (state == ST_SHIFT);
    assign done          = (state == ST_DONE);

endmodule
